data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Round-robin arbiter that shares one synchronous data RAM between N processor cores. Each core's data-side port (address from its pointer mux, write data from its ADDR register, and a memory-write control bit) becomes a requester. The arbiter serialises their accesses onto a single RAM port and returns read data with a per-core valid strobe. It sits between the cores' top register wrappers and the shared data memory.

## Interface

Parameters:
- N, 4, number of requesting cores (2..8)
- AW, 8, address width
- DW, 8, data width

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- req  input  N  per-core access request; bit i belongs to core i
- we  input  N  per-core write flag: 1 = write, 0 = read (MEMCtrl of each core)
- addr  input  N*AW  flattened addresses; core i at [i*AW +: AW]
- wdata  input  N*DW  flattened write data; core i at [i*DW +: DW]
- gnt  output  N  one-hot, one-cycle grant pulse
- rvalid  output  N  one-hot, one-cycle read-data-valid pulse
- rdata  output  DW  read data, broadcast to all cores; qualified by rvalid
- busy  output  1  high while a transaction is in flight
- mem_addr  output  AW  RAM address
- mem_wdata  output  DW  RAM write data
- mem_we  output  1  RAM write enable
- mem_rdata  input  DW  RAM read data; valid one cycle after the address is presented (synchronous read)

## Operation

FSM states: IDLE, ACCESS, RDWAIT.

- **IDLE:**
  - If req is all zero, stay in IDLE.
  - Otherwise pick a winner w by round-robin, starting the search at last+1 mod N, where last is the previously granted index.
  - On the same edge:
    - register mem_addr, mem_wdata and mem_we from core w's addr, wdata and we;
    - set gnt to one-hot(w);
    - set last = w;
    - store w and we[w];
    - go to ACCESS.
- **ACCESS:** the RAM samples mem_* in this cycle.
  - gnt returns to 0 on the next edge.
  - mem_we returns to 0 on the next edge.
  - Write: next state is IDLE.
  - Read: next state is RDWAIT.
- **RDWAIT:** mem_rdata is valid in this cycle.
  - On the edge: rdata <= mem_rdata, rvalid <= one-hot(w), next state is IDLE.
  - rvalid is a single-cycle pulse.
  - rdata holds its value until the next read completes.

Other rules:
- **busy** is 1 in ACCESS and RDWAIT, and also in the cycle where rvalid is high.
- **mem_addr / mem_wdata** hold their last values outside ACCESS. mem_we is 1 only in ACCESS cycles of write transactions.

Requester rules:
- Hold req, we, addr and wdata stable from req assertion until gnt[i] is seen high.
- Deassert req at the clock edge that ends the gnt cycle, unless another access is wanted.
- If req is still high when the arbiter next reaches IDLE, it is a new request.
- Dropping req before gnt withdraws the request. That is legal, and no grant is issued to that core.

Round-robin rule:
- Reset value of last is N-1, so core 0 has first priority after reset.
- A core that was just granted has the lowest priority in the next arbitration.

Reset (RST high, at any time, including mid-transaction):
- State goes to IDLE and last goes to N-1.
- gnt, rvalid, rdata, busy, mem_addr, mem_wdata and mem_we all go to 0.
- The in-flight transaction is dropped and no rvalid is issued for it.
- Normal arbitration resumes on the first rising edge after RST falls.

## Timing

- Arbitration decision: registered, taken on the IDLE edge. gnt is high during the ACCESS cycle.
- Write transaction: 2 cycles, IDLE sample then ACCESS. The RAM write commits at the edge ending ACCESS.
- Read transaction: 3 cycles from the IDLE sample edge to the rvalid pulse.
  - Edge 0: grant.
  - Edge 1: RAM captures the address.
  - Edge 2: rdata/rvalid are registered.
  - rvalid is high in the cycle after edge 2.
- Back-to-back throughput: one write per 2 cycles, one read per 3 cycles. There is no pipelining across transactions.
- Requests that arrive while busy wait. They are sampled only in IDLE.
- Worst-case wait for a continuously requesting core: N-1 other transactions.
- No combinational path exists from any input to any output, except none. All outputs are registered.

## Test plan

1. **Reset values.** Hold RST high with random inputs → all outputs are 0. Release RST with req=0 → all outputs stay 0 and busy=0.
2. **Single write then read.**
   - Core 2 writes addr 0x3C, wdata 0xA5 → gnt=0100 for one cycle; mem_we=1, mem_addr=0x3C and mem_wdata=0xA5 in the same cycle.
   - Core 2 then reads 0x3C → rvalid=0100 exactly 3 cycles after the sample edge, with rdata=0xA5.
3. **Round-robin fairness.** N=4, all req held high with reads → the grant order is 0,1,2,3,0,1… and each rvalid matches the preceding grant's core.
4. **Simultaneous requests after a grant.** Core 1 granted last; cores 0 and 1 request at the same time → core 2 is absent, so core 0 is granted before core 1 again.
5. **Withdrawn request.** Core 3 raises req while core 0's read is in RDWAIT, then drops it before IDLE → no gnt[3] and no RAM access.
6. **Reset mid-read.** Assert RST during RDWAIT of a core 1 read → no rvalid pulse. After release, a new core 1 request is granted first (last = N-1).

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bundle of signals between N requesting cores, the data-memory arbiter and the shared RAM.
// The arbiter uses the slave view; the requester/RAM side uses the master view.
interface data_mem_arbiter_if #(
    parameter int N  = 4,
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_we;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter serialising N cores' data accesses onto one synchronous-read RAM port.
// Every output is registered; reads take 3 cycles (grant, RAM address, data return), writes 2.
module data_mem_arbiter #(
    parameter int N  = 4,
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic               CLK,
    input  logic               RST,
    data_mem_arbiter_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_win;
    logic            r_is_wr;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    r_rvalid;
    logic [DW-1:0]   r_rdata;
    logic            r_busy;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_mem_we;

    logic [AW-1:0]   w_addr_arr  [N];
    logic [DW-1:0]   w_wdata_arr [N];
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_hi;
    logic [IW-1:0]   w_lo;
    logic            w_hi_found;
    logic            w_grant;
    logic [N-1:0]    w_gnt_nxt;
    logic [N-1:0]    w_rvalid_nxt;
    logic            w_mem_we_nxt;
    logic            w_busy_nxt;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_addr_arr[i]  = bus.addr[i*AW +: AW];
            w_wdata_arr[i] = bus.wdata[i*DW +: DW];
        end
    end

    // Round robin: lowest requester above r_last wins, otherwise wrap to the lowest requester.
    always_comb begin
        w_hi       = '0;
        w_lo       = '0;
        w_hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_lo = IW'(i);
                if (i > int'(r_last)) begin
                    w_hi       = IW'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_win = w_hi_found ? w_hi : w_lo;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (|bus.req) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = r_is_wr ? IDLE : RDWAIT;
            RDWAIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // busy also covers the rvalid cycle, which is the IDLE cycle right after RDWAIT.
    always_comb begin
        w_grant      = (r_state == IDLE) && (|bus.req);
        w_gnt_nxt    = '0;
        w_rvalid_nxt = '0;
        w_mem_we_nxt = 1'b0;
        if (w_grant) begin
            w_gnt_nxt    = N'(1) << w_win;
            w_mem_we_nxt = bus.we[w_win];
        end
        if (r_state == RDWAIT) begin
            w_rvalid_nxt = N'(1) << r_win;
        end
        w_busy_nxt = (w_state_nxt != IDLE) || (r_state == RDWAIT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last      <= IW'(N - 1);
            r_win       <= '0;
            r_is_wr     <= 1'b0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_mem_we <= w_mem_we_nxt;
            r_busy   <= w_busy_nxt;
            if (w_grant) begin
                r_mem_addr  <= w_addr_arr[w_win];
                r_mem_wdata <= w_wdata_arr[w_win];
                r_last      <= w_win;
                r_win       <= w_win;
                r_is_wr     <= bus.we[w_win];
            end
            if (r_state == RDWAIT) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rvalid    = r_rvalid;
    assign bus.rdata     = r_rdata;
    assign bus.busy      = r_busy;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random requesters, checked each cycle
// against a transaction-level model (priority distance, cycles-to-completion, shadow memory).
module tb_data_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic CLK;
    logic RST;

    data_mem_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

    data_mem_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shared RAM with synchronous read; filled from a fixed formula on its first clock.
    logic [DW-1:0] ram [2**AW];
    bit ram_ready = 1'b0;
    always @(posedge CLK) begin
        if (!ram_ready) begin
            for (int i = 0; i < 2**AW; i++) ram[i] <= DW'(i * 37 + 11);
            ram_ready <= 1'b1;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] shadow [2**AW];
    int            m_last;
    int            m_cnt;
    int            m_w;
    bit            m_is_write;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wval;
    logic [DW-1:0] m_exp_rd;
    logic [N-1:0]  e_gnt, e_rvalid;
    logic [DW-1:0] e_rdata, e_mwd;
    logic [AW-1:0] e_maddr;
    logic          e_busy, e_mwe;

    task automatic model_reset();
        m_cnt = 0; m_last = N - 1; m_w = 0; m_is_write = 1'b0;
        e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_busy = 1'b0;
        e_maddr = '0; e_mwd = '0; e_mwe = 1'b0;
    endtask

    // m_cnt counts edges until the arbiter can sample requests again.
    task automatic model_edge();
        int best, bestd;
        if (RST) begin
            model_reset();
            return;
        end
        e_gnt = '0; e_rvalid = '0; e_mwe = 1'b0;
        if (m_cnt == 0) begin
            best = -1; bestd = N + 1;
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    int d;
                    d = (i - m_last - 1 + 2 * N) % N;
                    if (d < bestd) begin bestd = d; best = i; end
                end
            end
            if (best >= 0) begin
                e_gnt      = N'(1) << best;
                e_maddr    = bus.addr[best*AW +: AW];
                e_mwd      = bus.wdata[best*DW +: DW];
                e_mwe      = bus.we[best];
                m_last     = best;
                m_w        = best;
                m_is_write = bus.we[best];
                if (m_is_write) begin
                    m_waddr = e_maddr; m_wval = e_mwd; m_cnt = 1;
                end else begin
                    m_exp_rd = shadow[e_maddr]; m_cnt = 2;
                end
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                if (m_is_write) shadow[m_waddr] = m_wval;
                else begin
                    e_rvalid = N'(1) << m_w;
                    e_rdata  = m_exp_rd;
                end
            end
        end
        e_busy = (m_cnt != 0) || (e_rvalid != '0);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("gnt",       64'(bus.gnt),       64'(e_gnt));
        chk("rvalid",    64'(bus.rvalid),    64'(e_rvalid));
        chk("rdata",     64'(bus.rdata),     64'(e_rdata));
        chk("busy",      64'(bus.busy),      64'(e_busy));
        chk("mem_we",    64'(bus.mem_we),    64'(e_mwe));
        chk("mem_addr",  64'(bus.mem_addr),  64'(e_maddr));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_mwd));
    endtask

    task automatic set_core(input int i, input bit r, input bit w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i] = r;
        bus.we[i]  = w;
        bus.addr[i*AW +: AW]  = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    task automatic rand_core(input int i);
        set_core(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        int k;
        for (int i = 0; i < 2**AW; i++) shadow[i] = DW'(i * 37 + 11);
        model_reset();
        RST = 1'b1;
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;

        // Reset held with random inputs, then released with req=0
        for (int c = 0; c < 4; c++) begin
            bus.req = N'($urandom); bus.we = N'($urandom);
            bus.addr = (N*AW)'({$urandom, $urandom}); bus.wdata = (N*DW)'({$urandom, $urandom});
            step();
        end
        #1;
        RST = 1'b0; bus.req = '0;
        for (int c = 0; c < 3; c++) step();

        // Core 2 write then read of 0x3C
        set_core(2, 1'b1, 1'b1, 8'h3C, 8'hA5);
        step();
        chk("wr_gnt",   64'(bus.gnt),       64'(4'b0100));
        chk("wr_we",    64'(bus.mem_we),    64'(1));
        chk("wr_addr",  64'(bus.mem_addr),  64'(8'h3C));
        chk("wr_wdata", 64'(bus.mem_wdata), 64'(8'hA5));
        bus.req = '0;
        step(); step();
        set_core(2, 1'b1, 1'b0, 8'h3C, 8'h00);
        step();
        bus.req = '0;
        step(); step();
        chk("rd_rvalid", 64'(bus.rvalid), 64'(4'b0100));
        chk("rd_rdata",  64'(bus.rdata),  64'(8'hA5));
        step();

        // Fairness from reset: all cores reading continuously
        RST = 1'b1; step(); RST = 1'b0;
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, AW'($urandom_range(0, 15)), 8'h00);
        k = 0;
        for (int c = 0; c < 36; c++) begin
            step();
            if (bus.gnt != '0) begin
                chk("rr_order", 64'(onehot_idx(bus.gnt)), 64'(k % N));
                k++;
            end
        end
        bus.req = '0;
        for (int c = 0; c < 3; c++) step();

        // Core 1 granted last; cores 0 and 1 then request together
        set_core(1, 1'b1, 1'b0, 8'h05, 8'h00);
        step(); bus.req = '0; step(); step(); step();
        set_core(0, 1'b1, 1'b0, 8'h06, 8'h00);
        set_core(1, 1'b1, 1'b0, 8'h07, 8'h00);
        step();
        chk("simul_gnt", 64'(bus.gnt), 64'(4'b0001));
        bus.req[0] = 1'b0;
        for (int c = 0; c < 6; c++) step();
        bus.req = '0;
        step();

        // Withdrawn request from core 3 while core 0 is in RDWAIT
        set_core(0, 1'b1, 1'b0, 8'h09, 8'h00);
        step(); bus.req = '0; step();
        set_core(3, 1'b1, 1'b1, 8'h33, 8'h77);
        step();
        bus.req[3] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("wd_gnt3", 64'(bus.gnt[3]), 64'(0));
            chk("wd_we",   64'(bus.mem_we), 64'(0));
        end

        // Reset during RDWAIT of a core 1 read
        set_core(1, 1'b1, 1'b0, 8'h0A, 8'h00);
        step(); bus.req = '0; step();
        RST = 1'b1;
        step();
        chk("rst_rvalid", 64'(bus.rvalid), 64'(0));
        RST = 1'b0;
        set_core(1, 1'b1, 1'b0, 8'h0B, 8'h00);
        set_core(2, 1'b1, 1'b0, 8'h0C, 8'h00);
        step();
        chk("rst_gnt", 64'(bus.gnt), 64'(4'b0010));
        bus.req = '0;
        for (int c = 0; c < 4; c++) step();

        // Random requesters with occasional withdrawal and reset
        for (int c = 0; c < 3000; c++) begin
            step();
            RST = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (bus.gnt[i]) begin
                    if ($urandom_range(0, 2) == 0) rand_core(i);
                    else bus.req[i] = 1'b0;
                end else if (bus.req[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    rand_core(i);
                end
            end
        end
        RST = 1'b0;
        bus.req = '0;
        for (int c = 0; c < 4; c++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
